box_tracker: RTL and testbench
==============================

# box_tracker

Builds the per-frame bounding box of thresholded pixels for the camera overlay. It samples the raster position (`DrawX`, `DrawY`) and the per-pixel threshold flag as the VGA scan advances. It accumulates the min/max extents and the first/last hit in raster order, then commits them once per frame. The committed `tlx/brx/tly/bry` and `topx/topy/bottomx/bottomy` outputs drive the color mapper's box, dot and trace overlays for the following frame.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `MIN_PIXELS`, 16: minimum hits per frame needed to accept the frame's box.
- `CNT_W`, 19: hit counter width; covers 640×480.

Ports:
- `Clk` in 1: system clock.
- `Reset_n` in 1: asynchronous active-low reset.
- `pixel_en` in 1: one-cycle strobe marking a valid raster position this cycle.
- `DrawX` in 10: current pixel column.
- `DrawY` in 10: current pixel row.
- `ABOVE_T` in 1: current pixel is within the colour threshold.
- `tlx`, `tly` out 10 each: committed box top-left corner.
- `brx`, `bry` out 10 each: committed box bottom-right corner.
- `topx`, `topy` out 10 each: first hit in raster order.
- `bottomx`, `bottomy` out 10 each: last hit in raster order.
- `box_valid` out 1: the last committed frame met `MIN_PIXELS`.
- `frame_done` out 1: one-cycle pulse on each commit.
- `hit_count` out `CNT_W`: hit total of the last completed frame.

## Operation
- A sample is active when `pixel_en`=1, `DrawX < H_ACTIVE` and `DrawY < V_ACTIVE`.
- A hit is an active sample with `ABOVE_T`=1.
- States:
  - IDLE: waits for an active sample at (0,0), which is the frame start.
  - ACCUM: accumulates.
  - COMMIT: updates outputs.
- IDLE→ACCUM on frame start. The (0,0) sample itself is accumulated.
- Each ACCUM frame begins with cleared accumulators:
  - `min_x`=`min_y`=10'h3FF, `max_x`=`max_y`=0.
  - `cnt`=0, `first_seen`=0.
- On each hit in ACCUM:
  - min/max update per axis.
  - `cnt` increments, saturating at all-ones.
  - If `first_seen`=0: capture (x,y) as first hit, then set `first_seen`=1.
  - Always capture (x,y) as last hit.
- ACCUM→COMMIT on the active sample at (`H_ACTIVE`-1, `V_ACTIVE`-1). That sample is accumulated first.
- COMMIT, one cycle, always returns to IDLE:
  - `hit_count` ← `cnt`.
  - `frame_done`=1.
  - If `cnt >= MIN_PIXELS`: `box_valid` ← 1, and box, top and bottom outputs ← accumulators.
  - Otherwise: `box_valid` ← 0, and all coordinate outputs hold their previous values.
- A frame start seen while in ACCUM (source restart or skipped pixels) discards the partial frame. Accumulators re-clear and then take the (0,0) sample; the state stays ACCUM and there is no commit.
- `pixel_en`=0 or non-active positions never change the accumulators or the state.
- Reset, at any time:
  - State → IDLE, accumulators cleared.
  - All outputs 0; `box_valid`=0, `frame_done`=0.
  - A frame in progress when reset releases is never committed. The first commit follows the first complete frame.

## Timing
- Accumulators update on the `Clk` edge that samples the qualifying `pixel_en` cycle.
- Final pixel sampled at edge N → state is COMMIT during cycle N..N+1.
- Outputs, `hit_count` and `box_valid` change at edge N+1.
- `frame_done` is high for exactly cycle N+1..N+2.
- Outputs are registered and stable between commits. They never glitch during a frame.
- The block requires at least 2 `Clk` cycles between `pixel_en` strobes, so COMMIT never overlaps a sample.

## Structure
- Package `box_pkg` holds:
  - `coord_t` (logic [9:0]).
  - `box_state_e` {IDLE, ACCUM, COMMIT}.
  - Default `H_ACTIVE`/`V_ACTIVE` constants.
  - `COORD_INIT_MIN` = 10'h3FF.
- Sub-module `extent_acc` provides the per-axis min/max register pair with `clear`/`sample` inputs. It is instantiated twice, once for X and once for Y.

## Test plan
- Reset mid-frame, then one full frame with a single 4×4 hit block at (100..103, 50..53), `MIN_PIXELS`=16. Required response:
  - `tlx`=100, `tly`=50, `brx`=103, `bry`=53.
  - `topx/topy`=100/50, `bottomx/bottomy`=103/53.
  - `hit_count`=16, `box_valid`=1.
  - `frame_done` is a single 1-cycle pulse, one cycle after (639,479).
- Next frame has only 3 hits → `box_valid`=0, `hit_count`=3, all coordinate outputs hold 100/50/103/53.
- Hits only at (0,0) and (639,479), with `MIN_PIXELS`=2 → box is 0,0,639,479; top (0,0); bottom (639,479).
- Frame restarts at (0,0) mid-ACCUM after 100 hits → no `frame_done`; the next commit reflects only the restarted frame.
- `pixel_en` held low with `ABOVE_T`=1 for a whole raster sweep → no accumulation and no commit.
- All-hit frame → `hit_count`=307200, box 0,0,639,479.

Source files
------------

// File: rtl/box_pkg.sv
// box_pkg: shared types and constants for the bounding-box tracker.
package box_pkg;

  // Screen coordinate, wide enough for any 10-bit raster position.
  typedef logic [9:0] coord_t;

  // Frame life cycle: wait for (0,0), gather hits, publish results.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    COMMIT = 2'd2
  } box_state_e;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;

  // Empty-range seeds: any real coordinate replaces them on the first hit.
  localparam coord_t COORD_INIT_MIN = 10'h3FF;
  localparam coord_t COORD_INIT_MAX = 10'h000;

  // Last on-screen coordinate along an axis with the given active length.
  function automatic coord_t lastCoord(input int activeLen);
    return coord_t'(activeLen - 1);
  endfunction

endpackage

// File: rtl/extent_acc.sv
// extent_acc: running min/max of one coordinate axis over a frame.
// A clear and a sample in the same cycle means "start a new range with this
// value", which is exactly what a frame-start hit at (0,0) needs.
module extent_acc
  import box_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_clear,
  input  logic   i_sample,
  input  coord_t i_value,
  output coord_t o_min,
  output coord_t o_max
);

  coord_t r_min;
  coord_t r_max;
  coord_t w_baseMin;
  coord_t w_baseMax;
  coord_t w_nextMin;
  coord_t w_nextMax;

  // Next extents: optionally fall back to the empty range, then fold in the sample.
  always_comb begin
    w_baseMin = i_clear ? COORD_INIT_MIN : r_min;
    w_baseMax = i_clear ? COORD_INIT_MAX : r_max;
    w_nextMin = w_baseMin;
    w_nextMax = w_baseMax;
    if (i_sample) begin
      if (i_value < w_baseMin) begin
        w_nextMin = i_value;
      end
      if (i_value > w_baseMax) begin
        w_nextMax = i_value;
      end
    end
  end

  // Extent registers, reset to the empty range.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_min <= COORD_INIT_MIN;
      r_max <= COORD_INIT_MAX;
    end else begin
      r_min <= w_nextMin;
      r_max <= w_nextMax;
    end
  end

  assign o_min = r_min;
  assign o_max = r_max;

endmodule

// File: rtl/box_tracker.sv
// box_tracker: per-frame bounding box, first and last hit of thresholded
// pixels. Results are published once per complete frame and held steady
// for the overlay logic while the next frame is being gathered.
module box_tracker
  import box_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE   = V_ACTIVE_DEFAULT,
  parameter int MIN_PIXELS = 16,
  parameter int CNT_W      = 19
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             pixel_en,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             ABOVE_T,
  output logic [9:0]       tlx,
  output logic [9:0]       tly,
  output logic [9:0]       brx,
  output logic [9:0]       bry,
  output logic [9:0]       topx,
  output logic [9:0]       topy,
  output logic [9:0]       bottomx,
  output logic [9:0]       bottomy,
  output logic             box_valid,
  output logic             frame_done,
  output logic [CNT_W-1:0] hit_count
);

  localparam coord_t           LAST_X  = lastCoord(H_ACTIVE);
  localparam coord_t           LAST_Y  = lastCoord(V_ACTIVE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

  box_state_e r_state;
  box_state_e w_nextState;

  logic w_active;
  logic w_frameStart;
  logic w_frameEnd;
  logic w_clearAcc;
  logic w_acceptSample;
  logic w_sampleHit;
  logic w_commit;
  logic w_meetsMin;

  coord_t w_minX;
  coord_t w_maxX;
  coord_t w_minY;
  coord_t w_maxY;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntBase;
  logic             r_firstSeen;
  logic             w_firstSeenBase;
  coord_t           r_firstX;
  coord_t           r_firstY;
  coord_t           r_lastX;
  coord_t           r_lastY;

  // Classify the current raster position: on-screen, frame start, frame end.
  always_comb begin
    w_active     = pixel_en && (DrawX <= LAST_X) && (DrawY <= LAST_Y);
    w_frameStart = w_active && (DrawX == '0) && (DrawY == '0);
    w_frameEnd   = w_active && (DrawX == LAST_X) && (DrawY == LAST_Y);
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and accumulator controls; a (0,0) seen mid-frame restarts the frame.
  always_comb begin
    w_nextState    = r_state;
    w_clearAcc     = 1'b0;
    w_acceptSample = 1'b0;
    w_commit       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_frameStart) begin
          w_nextState    = ACCUM;
          w_clearAcc     = 1'b1;
          w_acceptSample = 1'b1;
        end
      end
      ACCUM: begin
        if (w_frameStart) begin
          w_clearAcc     = 1'b1;
          w_acceptSample = 1'b1;
        end else if (w_active) begin
          w_acceptSample = 1'b1;
          if (w_frameEnd) begin
            w_nextState = COMMIT;
          end
        end
      end
      COMMIT: begin
        w_commit    = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign w_sampleHit = w_acceptSample && ABOVE_T;

  // Per-axis extents of the hits in the current frame.
  extent_acc u_extentX (
    .i_clk    (Clk),
    .i_rst_n  (Reset_n),
    .i_clear  (w_clearAcc),
    .i_sample (w_sampleHit),
    .i_value  (DrawX),
    .o_min    (w_minX),
    .o_max    (w_maxX)
  );

  extent_acc u_extentY (
    .i_clk    (Clk),
    .i_rst_n  (Reset_n),
    .i_clear  (w_clearAcc),
    .i_sample (w_sampleHit),
    .i_value  (DrawY),
    .o_min    (w_minY),
    .o_max    (w_maxY)
  );

  // Starting point for this cycle's update: cleared values on a frame start.
  always_comb begin
    w_cntBase       = w_clearAcc ? '0 : r_cnt;
    w_firstSeenBase = w_clearAcc ? 1'b0 : r_firstSeen;
  end

  // Hit counter (saturating) and first/last hit capture in arrival order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt       <= '0;
      r_firstSeen <= 1'b0;
      r_firstX    <= '0;
      r_firstY    <= '0;
      r_lastX     <= '0;
      r_lastY     <= '0;
    end else begin
      r_cnt       <= w_cntBase;
      r_firstSeen <= w_firstSeenBase;
      if (w_clearAcc) begin
        r_firstX <= '0;
        r_firstY <= '0;
        r_lastX  <= '0;
        r_lastY  <= '0;
      end
      if (w_sampleHit) begin
        if (w_cntBase != CNT_MAX) begin
          r_cnt <= w_cntBase + 1'b1;
        end
        if (!w_firstSeenBase) begin
          r_firstX    <= DrawX;
          r_firstY    <= DrawY;
          r_firstSeen <= 1'b1;
        end
        r_lastX <= DrawX;
        r_lastY <= DrawY;
      end
    end
  end

  assign w_meetsMin = (r_cnt >= MIN_CNT);

  // Published results: updated only in the commit cycle; coordinates are kept
  // from the last good frame when too few pixels were seen.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tlx        <= '0;
      tly        <= '0;
      brx        <= '0;
      bry        <= '0;
      topx       <= '0;
      topy       <= '0;
      bottomx    <= '0;
      bottomy    <= '0;
      box_valid  <= 1'b0;
      frame_done <= 1'b0;
      hit_count  <= '0;
    end else begin
      frame_done <= w_commit;
      if (w_commit) begin
        hit_count <= r_cnt;
        box_valid <= w_meetsMin;
        if (w_meetsMin) begin
          tlx     <= w_minX;
          tly     <= w_minY;
          brx     <= w_maxX;
          bry     <= w_maxY;
          topx    <= r_firstX;
          topy    <= r_firstY;
          bottomx <= r_lastX;
          bottomy <= r_lastY;
        end
      end
    end
  end

endmodule

// File: tb/tb_box_tracker.sv
// tb_box_tracker: three tracker instances (default geometry, default geometry
// with a 2-pixel threshold, and a 16x8 screen with a 7-bit counter) driven
// one at a time and checked against a bitmap model of each frame.
module tb_box_tracker;

  typedef struct packed {
    int tlx;
    int tly;
    int brx;
    int bry;
    int topx;
    int topy;
    int botx;
    int boty;
    int valid;
    int done;
    int count;
  } outs_t;

  typedef struct packed {
    int    x0;
    int    y0;
    int    x1;
    int    y1;
    outs_t exp;
  } frameVec_t;

  logic clk = 1'b0;
  logic rstN;

  logic       pixEn  [3];
  logic [9:0] drawX  [3];
  logic [9:0] drawY  [3];
  logic       aboveT [3];

  logic [9:0] oTlx  [3];
  logic [9:0] oTly  [3];
  logic [9:0] oBrx  [3];
  logic [9:0] oBry  [3];
  logic [9:0] oTopx [3];
  logic [9:0] oTopy [3];
  logic [9:0] oBotx [3];
  logic [9:0] oBoty [3];
  logic       oValid[3];
  logic       oDone [3];

  logic [18:0] hcBig;
  logic [18:0] hcMin2;
  logic [6:0]  hcTiny;

  int nChecks;
  int nFail;

  // Model state: hit bitmap of the frame in progress and expected outputs.
  bit    hitMap [3][480][640];
  bit    inFrame[3];
  outs_t expOut [3];

  always #5 clk = ~clk;

  box_tracker u_big (
    .Clk(clk), .Reset_n(rstN), .pixel_en(pixEn[0]), .DrawX(drawX[0]), .DrawY(drawY[0]),
    .ABOVE_T(aboveT[0]), .tlx(oTlx[0]), .tly(oTly[0]), .brx(oBrx[0]), .bry(oBry[0]),
    .topx(oTopx[0]), .topy(oTopy[0]), .bottomx(oBotx[0]), .bottomy(oBoty[0]),
    .box_valid(oValid[0]), .frame_done(oDone[0]), .hit_count(hcBig)
  );

  box_tracker #(.MIN_PIXELS(2)) u_min2 (
    .Clk(clk), .Reset_n(rstN), .pixel_en(pixEn[1]), .DrawX(drawX[1]), .DrawY(drawY[1]),
    .ABOVE_T(aboveT[1]), .tlx(oTlx[1]), .tly(oTly[1]), .brx(oBrx[1]), .bry(oBry[1]),
    .topx(oTopx[1]), .topy(oTopy[1]), .bottomx(oBotx[1]), .bottomy(oBoty[1]),
    .box_valid(oValid[1]), .frame_done(oDone[1]), .hit_count(hcMin2)
  );

  box_tracker #(.H_ACTIVE(16), .V_ACTIVE(8), .MIN_PIXELS(2), .CNT_W(7)) u_tiny (
    .Clk(clk), .Reset_n(rstN), .pixel_en(pixEn[2]), .DrawX(drawX[2]), .DrawY(drawY[2]),
    .ABOVE_T(aboveT[2]), .tlx(oTlx[2]), .tly(oTly[2]), .brx(oBrx[2]), .bry(oBry[2]),
    .topx(oTopx[2]), .topy(oTopy[2]), .bottomx(oBotx[2]), .bottomy(oBoty[2]),
    .box_valid(oValid[2]), .frame_done(oDone[2]), .hit_count(hcTiny)
  );

  function automatic int hOf(input int sel);
    return (sel == 2) ? 16 : 640;
  endfunction

  function automatic int vOf(input int sel);
    return (sel == 2) ? 8 : 480;
  endfunction

  function automatic int minOf(input int sel);
    return (sel == 0) ? 16 : 2;
  endfunction

  function automatic int cntMaxOf(input int sel);
    return (sel == 2) ? 127 : 524287;
  endfunction

  function automatic outs_t mkOuts(input int tlx, input int tly, input int brx, input int bry,
                                   input int topx, input int topy, input int botx, input int boty,
                                   input int valid, input int done, input int count);
    outs_t o;
    o.tlx = tlx; o.tly = tly; o.brx = brx; o.bry = bry;
    o.topx = topx; o.topy = topy; o.botx = botx; o.boty = boty;
    o.valid = valid; o.done = done; o.count = count;
    return o;
  endfunction

  function automatic outs_t readOuts(input int sel);
    outs_t o;
    o.tlx   = int'(oTlx[sel]);
    o.tly   = int'(oTly[sel]);
    o.brx   = int'(oBrx[sel]);
    o.bry   = int'(oBry[sel]);
    o.topx  = int'(oTopx[sel]);
    o.topy  = int'(oTopy[sel]);
    o.botx  = int'(oBotx[sel]);
    o.boty  = int'(oBoty[sel]);
    o.valid = int'(oValid[sel]);
    o.done  = int'(oDone[sel]);
    case (sel)
      0:       o.count = int'(hcBig);
      1:       o.count = int'(hcMin2);
      default: o.count = int'(hcTiny);
    endcase
    return o;
  endfunction

  task automatic checkOutput(input int sel, input outs_t exp, input string name);
    outs_t act;
    act = readOuts(sel);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s dut%0d: got box=%0d,%0d,%0d,%0d top=%0d,%0d bot=%0d,%0d valid=%0d done=%0d count=%0d | expected box=%0d,%0d,%0d,%0d top=%0d,%0d bot=%0d,%0d valid=%0d done=%0d count=%0d",
               name, sel, act.tlx, act.tly, act.brx, act.bry, act.topx, act.topy, act.botx, act.boty,
               act.valid, act.done, act.count, exp.tlx, exp.tly, exp.brx, exp.bry, exp.topx, exp.topy,
               exp.botx, exp.boty, exp.valid, exp.done, exp.count);
    end
  endtask

  task automatic modelClear(input int sel);
    for (int y = 0; y < vOf(sel); y++) begin
      for (int x = 0; x < hOf(sel); x++) begin
        hitMap[sel][y][x] = 1'b0;
      end
    end
  endtask

  // Publish a frame: scan the bitmap in raster order for count, extents, first and last hit.
  task automatic modelCommit(input int sel);
    int cnt;
    int fx, fy, lx, ly, mnx, mny, mxx, mxy;
    cnt = 0; fx = -1; fy = 0; lx = 0; ly = 0; mnx = 1023; mny = 1023; mxx = 0; mxy = 0;
    for (int y = 0; y < vOf(sel); y++) begin
      for (int x = 0; x < hOf(sel); x++) begin
        if (hitMap[sel][y][x]) begin
          cnt++;
          if (fx < 0) begin
            fx = x; fy = y;
          end
          lx = x; ly = y;
          if (x < mnx) mnx = x;
          if (x > mxx) mxx = x;
          if (y < mny) mny = y;
          if (y > mxy) mxy = y;
        end
      end
    end
    if (cnt > cntMaxOf(sel)) cnt = cntMaxOf(sel);
    expOut[sel].count = cnt;
    expOut[sel].done  = 1;
    if (cnt >= minOf(sel)) begin
      expOut[sel].valid = 1;
      expOut[sel].tlx = mnx; expOut[sel].tly = mny;
      expOut[sel].brx = mxx; expOut[sel].bry = mxy;
      expOut[sel].topx = fx; expOut[sel].topy = fy;
      expOut[sel].botx = lx; expOut[sel].boty = ly;
    end else begin
      expOut[sel].valid = 0;
    end
  endtask

  task automatic modelPixel(input int sel, input int x, input int y, input bit en, input bit t);
    bit active;
    expOut[sel].done = 0;
    active = en && (x < hOf(sel)) && (y < vOf(sel));
    if (!active) return;
    if (x == 0 && y == 0) begin
      modelClear(sel);
      inFrame[sel] = 1'b1;
    end
    if (!inFrame[sel]) return;
    if (t) hitMap[sel][y][x] = 1'b1;
    if (x == hOf(sel) - 1 && y == vOf(sel) - 1) begin
      modelCommit(sel);
      inFrame[sel] = 1'b0;
    end
  endtask

  // One strobe: outputs must hold just after the sampling edge, then match the model one edge later.
  task automatic applyStimulus(input int sel, input int x, input int y, input bit en, input bit t);
    outs_t prev;
    @(negedge clk);
    pixEn[sel]  = en;
    drawX[sel]  = 10'(x);
    drawY[sel]  = 10'(y);
    aboveT[sel] = t;
    prev = expOut[sel];
    prev.done = 0;
    @(posedge clk);
    #1;
    pixEn[sel] = 1'b0;
    checkOutput(sel, prev, "holdAfterSample");
    modelPixel(sel, x, y, en, t);
    @(posedge clk);
    #1;
    checkOutput(sel, expOut[sel], "afterSample");
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    for (int s = 0; s < 3; s++) begin
      inFrame[s] = 1'b0;
      expOut[s]  = '0;
      pixEn[s]   = 1'b0;
    end
    #1;
    for (int s = 0; s < 3; s++) begin
      checkOutput(s, expOut[s], "resetState");
    end
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic sendRectFrame(input int sel, input int x0, input int y0, input int x1, input int y1);
    applyStimulus(sel, 0, 0, 1'b1, 1'b0);
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        applyStimulus(sel, x, y, 1'b1, 1'b1);
      end
    end
    applyStimulus(sel, hOf(sel) - 1, vOf(sel) - 1, 1'b1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    frameVec_t frames[3];
    int h, v, total, idx, stepMax, pHit, r;
    bit restarted;

    frames[0] = '{100, 50, 103, 53, mkOuts(100, 50, 103, 53, 100, 50, 103, 53, 1, 1, 16)};
    frames[1] = '{200, 10, 202, 10, mkOuts(100, 50, 103, 53, 100, 50, 103, 53, 0, 1, 3)};
    frames[2] = '{5, 300, 9, 303, mkOuts(5, 300, 9, 303, 5, 300, 9, 303, 1, 1, 20)};

    nChecks = 0;
    nFail   = 0;
    for (int s = 0; s < 3; s++) begin
      pixEn[s] = 1'b0; drawX[s] = '0; drawY[s] = '0; aboveT[s] = 1'b0;
      inFrame[s] = 1'b0; expOut[s] = '0;
    end
    rstN = 1'b1;
    #2;
    applyReset();

    // Reset in the middle of a frame; the rest of that frame must not commit.
    applyStimulus(0, 0, 0, 1'b1, 1'b1);
    applyStimulus(0, 10, 5, 1'b1, 1'b1);
    applyStimulus(0, 20, 6, 1'b1, 1'b1);
    applyReset();
    applyStimulus(0, 30, 7, 1'b1, 1'b1);
    applyStimulus(0, 639, 479, 1'b1, 1'b1);

    // Table-driven frames: accepted box, too-few-hits hold, new box.
    for (int i = 0; i < 3; i++) begin
      sendRectFrame(0, frames[i].x0, frames[i].y0, frames[i].x1, frames[i].y1);
      checkOutput(0, frames[i].exp, "tableFrame");
    end

    // Hits only at the two screen corners.
    applyStimulus(1, 0, 0, 1'b1, 1'b1);
    applyStimulus(1, 639, 479, 1'b1, 1'b1);
    checkOutput(1, mkOuts(0, 0, 639, 479, 0, 0, 639, 479, 1, 1, 2), "cornersFrame");

    // Restart at (0,0) after 100 hits: no commit, and only the restarted frame counts.
    applyStimulus(1, 0, 0, 1'b1, 1'b0);
    for (int x = 0; x < 100; x++) applyStimulus(1, x, 10, 1'b1, 1'b1);
    applyStimulus(1, 0, 0, 1'b1, 1'b0);
    for (int y = 200; y <= 201; y++) begin
      for (int x = 300; x <= 301; x++) applyStimulus(1, x, y, 1'b1, 1'b1);
    end
    applyStimulus(1, 639, 479, 1'b1, 1'b0);
    checkOutput(1, mkOuts(300, 200, 301, 201, 300, 200, 301, 201, 1, 1, 4), "restartFrame");

    // Whole sweep with pixel_en low: nothing may change.
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 16; x++) applyStimulus(2, x, y, 1'b0, 1'b1);
    end
    checkOutput(2, '0, "enableLowSweep");

    // Every pixel a hit: 128 hits saturate the 7-bit counter.
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 16; x++) applyStimulus(2, x, y, 1'b1, 1'b1);
    end
    checkOutput(2, mkOuts(0, 0, 15, 7, 0, 0, 15, 7, 1, 1, 127), "allHitSaturate");

    // Random sparse frames in raster order with idle strobes, off-screen samples and a restart.
    for (int sel = 0; sel < 3; sel++) begin
      for (int f = 0; f < 6; f++) begin
        h = hOf(sel);
        v = vOf(sel);
        total = h * v;
        stepMax = (sel == 2) ? 6 : total / 30;
        pHit = ($urandom_range(0, 3) == 0) ? 5 : 60;
        restarted = 1'b0;
        applyStimulus(sel, 0, 0, 1'b1, $urandom_range(0, 99) < pHit);
        idx = 0;
        while (1) begin
          idx = idx + int'($urandom_range(1, stepMax));
          if (idx >= total - 1) break;
          r = int'($urandom_range(0, 19));
          if (r == 0) begin
            applyStimulus(sel, idx % h, idx / h, 1'b0, 1'b1);
          end else if (r == 1) begin
            applyStimulus(sel, h + int'($urandom_range(0, 1023 - h)), int'($urandom_range(0, 1023)), 1'b1, 1'b1);
          end else if (r == 2 && f == 3 && !restarted) begin
            applyStimulus(sel, 0, 0, 1'b1, $urandom_range(0, 99) < pHit);
            idx = 0;
            restarted = 1'b1;
          end else begin
            applyStimulus(sel, idx % h, idx / h, 1'b1, $urandom_range(0, 99) < pHit);
          end
        end
        applyStimulus(sel, h - 1, v - 1, 1'b1, $urandom_range(0, 99) < pHit);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
